// File: rtl/round_judge.sv
// Two-player card round judge: collects one card per player, scores the round,
// and declares a game winner after nine judged rounds.
module round_judge (
    input  logic       clk,
    input  logic       resetn,
    input  logic       p1_played,
    input  logic [3:0] p1_handcard,
    input  logic       p2_played,
    input  logic [3:0] p2_handcard,
    input  logic       restart,
    output logic       result_valid,
    output logic [1:0] round_winner,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [3:0] round_cnt,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       play_err
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_HAVE1,
        S_HAVE2,
        S_JUDGE,
        S_OVER
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;
    localparam logic [3:0] MAX_CNT  = 4'd9;

    state_t     state_q, state_d;
    logic [3:0] c1_q, c1_d;
    logic [3:0] c2_q, c2_d;
    logic       result_valid_q, result_valid_d;
    logic [1:0] round_winner_q, round_winner_d;
    logic [3:0] p1_score_q, p1_score_d;
    logic [3:0] p2_score_q, p2_score_d;
    logic [3:0] round_cnt_q, round_cnt_d;
    logic       game_over_q, game_over_d;
    logic [1:0] winner_q, winner_d;
    logic       play_err_q, play_err_d;

    logic       p1_ok, p1_bad, p2_ok, p2_bad;
    logic [3:0] v1, v2;

    function automatic logic card_ok(input logic [3:0] idx);
        return idx <= 4'd8;
    endfunction

    // Counters saturate at 9 rather than wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= MAX_CNT) ? MAX_CNT : v + 4'd1;
    endfunction

    function automatic logic [1:0] compare(input logic [3:0] a, input logic [3:0] b);
        if (a > b)      return WIN_P1;
        else if (b > a) return WIN_P2;
        else            return WIN_DRAW;
    endfunction

    assign p1_ok  = p1_played &&  card_ok(p1_handcard);
    assign p1_bad = p1_played && !card_ok(p1_handcard);
    assign p2_ok  = p2_played &&  card_ok(p2_handcard);
    assign p2_bad = p2_played && !card_ok(p2_handcard);

    always_comb begin
        state_d        = state_q;
        c1_d           = c1_q;
        c2_d           = c2_q;
        result_valid_d = 1'b0;
        round_winner_d = round_winner_q;
        p1_score_d     = p1_score_q;
        p2_score_d     = p2_score_q;
        round_cnt_d    = round_cnt_q;
        game_over_d    = game_over_q;
        winner_d       = winner_q;
        play_err_d     = 1'b0;
        v1             = c1_q + 4'd1;
        v2             = c2_q + 4'd1;

        case (state_q)
            S_WAIT: begin
                play_err_d = p1_bad | p2_bad;
                if (p1_ok && p2_ok) begin
                    c1_d    = p1_handcard;
                    c2_d    = p2_handcard;
                    state_d = S_JUDGE;
                end else if (p1_ok) begin
                    c1_d    = p1_handcard;
                    state_d = S_HAVE1;
                end else if (p2_ok) begin
                    c2_d    = p2_handcard;
                    state_d = S_HAVE2;
                end
            end
            S_HAVE1: begin
                play_err_d = p1_played | p2_bad;
                if (p2_ok) begin
                    c2_d    = p2_handcard;
                    state_d = S_JUDGE;
                end
            end
            S_HAVE2: begin
                play_err_d = p2_played | p1_bad;
                if (p1_ok) begin
                    c1_d    = p1_handcard;
                    state_d = S_JUDGE;
                end
            end
            S_JUDGE: begin
                play_err_d     = p1_played | p2_played;
                result_valid_d = 1'b1;
                round_winner_d = compare(v1, v2);
                if (round_winner_d == WIN_P1) p1_score_d = sat_inc(p1_score_q);
                if (round_winner_d == WIN_P2) p2_score_d = sat_inc(p2_score_q);
                round_cnt_d = sat_inc(round_cnt_q);
                // Final verdict uses the scores including this last round.
                if (round_cnt_d == MAX_CNT) begin
                    state_d     = S_OVER;
                    game_over_d = 1'b1;
                    winner_d    = compare(p1_score_d, p2_score_d);
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_OVER: begin
                play_err_d  = p1_played | p2_played;
                game_over_d = 1'b1;
                if (restart) begin
                    state_d        = S_WAIT;
                    c1_d           = 4'd0;
                    c2_d           = 4'd0;
                    round_winner_d = WIN_NONE;
                    p1_score_d     = 4'd0;
                    p2_score_d     = 4'd0;
                    round_cnt_d    = 4'd0;
                    game_over_d    = 1'b0;
                    winner_d       = WIN_NONE;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= S_WAIT;
            c1_q           <= 4'd0;
            c2_q           <= 4'd0;
            result_valid_q <= 1'b0;
            round_winner_q <= WIN_NONE;
            p1_score_q     <= 4'd0;
            p2_score_q     <= 4'd0;
            round_cnt_q    <= 4'd0;
            game_over_q    <= 1'b0;
            winner_q       <= WIN_NONE;
            play_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            c1_q           <= c1_d;
            c2_q           <= c2_d;
            result_valid_q <= result_valid_d;
            round_winner_q <= round_winner_d;
            p1_score_q     <= p1_score_d;
            p2_score_q     <= p2_score_d;
            round_cnt_q    <= round_cnt_d;
            game_over_q    <= game_over_d;
            winner_q       <= winner_d;
            play_err_q     <= play_err_d;
        end
    end

    assign result_valid = result_valid_q;
    assign round_winner = round_winner_q;
    assign p1_score     = p1_score_q;
    assign p2_score     = p2_score_q;
    assign round_cnt    = round_cnt_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;
    assign play_err     = play_err_q;

endmodule
